// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Watches the store port of a processor data bus and checks that the stores
//   it makes are exactly the entries of a small expected-write table, in table
//   order. A run begins with a start pulse. The run ends in PASS once every
//   entry has been matched. It ends in FAIL on the first unexpected store or
//   when too many cycles pass without an accepted store. Stores to one scratch
//   address can be tolerated, so that code which keeps a loop counter in
//   memory does not trip the checker.
//
// Ports
//   clk, reset             clock and synchronous active-high reset
//   start                  one-cycle pulse that begins or restarts a run
//   exp_we/exp_idx         table write strobe and entry index (not in RUN)
//   exp_addr/exp_data      expected address/data for the addressed entry
//   memwrite               monitored store strobe
//   dataadr/writedata      monitored store address/data
//   busy/done/pass/fail    registered state decodes
//   fail_code              0 none, 1 mismatch, 2 timeout
//   match_cnt              number of table entries matched so far
//   fail_addr/fail_data    offending store captured on a mismatch
module mem_write_checker #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              N_EXP    = 4,
  parameter int              TIMEOUT  = 1000,
  parameter logic [AW-1:0]   IGN_ADDR = AW'(32'd80),
  parameter bit              IGN_EN   = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       exp_we,
  input  logic [((N_EXP > 1) ? $clog2(N_EXP) : 1)-1:0] exp_idx,
  input  logic [AW-1:0]                              exp_addr,
  input  logic [DW-1:0]                              exp_data,
  input  logic                                       memwrite,
  input  logic [AW-1:0]                              dataadr,
  input  logic [DW-1:0]                              writedata,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       pass,
  output logic                                       fail,
  output logic [1:0]                                 fail_code,
  output logic [$clog2(N_EXP+1)-1:0]                 match_cnt,
  output logic [AW-1:0]                              fail_addr,
  output logic [DW-1:0]                              fail_data
);

  localparam int IW = (N_EXP > 1) ? $clog2(N_EXP) : 1;
  localparam int CW = $clog2(N_EXP + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_FULL    = CW'(N_EXP);
  localparam logic [TW-1:0] TMO_LIMIT   = TW'(TIMEOUT);
  localparam logic [1:0]    FC_NONE     = 2'd0;
  localparam logic [1:0]    FC_MISMATCH = 2'd1;
  localparam logic [1:0]    FC_TIMEOUT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            r_fail;
  logic [1:0]      r_fail_code;
  logic [CW-1:0]   r_match_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic [AW-1:0]   r_fail_addr;
  logic [DW-1:0]   r_fail_data;

  logic [AW-1:0]   r_tbl_addr [N_EXP];
  logic [DW-1:0]   r_tbl_data [N_EXP];

  logic [AW-1:0]   w_cur_addr;
  logic [DW-1:0]   w_cur_data;
  logic            w_ign;
  logic            w_hit;
  logic [CW-1:0]   w_cnt_inc;
  logic [TW-1:0]   w_tmo_inc;
  logic            w_tmo_hit;

  // Select the entry the next store must match. In RUN, match_cnt is always
  // below N_EXP, so exactly one entry is selected.
  always_comb begin
    w_cur_addr = '0;
    w_cur_data = '0;
    for (int i = 0; i < N_EXP; i++) begin
      w_cur_addr = (r_match_cnt == CW'(i)) ? r_tbl_addr[i] : w_cur_addr;
      w_cur_data = (r_match_cnt == CW'(i)) ? r_tbl_data[i] : w_cur_data;
    end
  end

  // A tolerated scratch store is neither a match nor a mismatch.
  assign w_ign     = IGN_EN && (dataadr == IGN_ADDR);
  assign w_hit     = (dataadr == w_cur_addr) && (writedata == w_cur_data);
  assign w_cnt_inc = r_match_cnt + CW'(1'b1);
  assign w_tmo_inc = r_tmo_cnt + TW'(1'b1);
  assign w_tmo_hit = (w_tmo_inc == TMO_LIMIT);

  // Expected-write table. It is frozen while a run is in progress. Indices at
  // or above N_EXP match no entry, so they are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_EXP; i++) begin
        r_tbl_addr[i] <= '0;
        r_tbl_data[i] <= '0;
      end
    end else if (exp_we && (r_state != ST_RUN)) begin
      for (int i = 0; i < N_EXP; i++) begin
        if (exp_idx == IW'(i)) begin
          r_tbl_addr[i] <= exp_addr;
          r_tbl_data[i] <= exp_data;
        end
      end
    end
  end

  // Checker FSM, with its status outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= FC_NONE;
      r_match_cnt <= '0;
      r_tmo_cnt   <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // A real store (not the scratch address) decides the cycle ahead
          // of the timeout, so a match on the last allowed cycle still counts.
          if (memwrite && !w_ign) begin
            if (w_hit) begin
              r_match_cnt <= w_cnt_inc;
              r_tmo_cnt   <= '0;
              if (w_cnt_inc == CNT_FULL) begin
                r_state <= ST_PASS;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_pass  <= 1'b1;
              end
            end else begin
              r_state     <= ST_FAIL;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_fail      <= 1'b1;
              r_fail_code <= FC_MISMATCH;
              r_fail_addr <= dataadr;
              r_fail_data <= writedata;
            end
          end else if (w_tmo_hit) begin
            r_state     <= ST_FAIL;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_fail      <= 1'b1;
            r_fail_code <= FC_TIMEOUT;
            r_tmo_cnt   <= w_tmo_inc;
          end else begin
            r_tmo_cnt <= w_tmo_inc;
          end
        end
        ST_IDLE, ST_PASS, ST_FAIL: begin
          // Outside RUN, everything holds until a start pulse arrives.
          if (start) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_code <= FC_NONE;
            r_match_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_pass      <= 1'b0;
          r_fail      <= 1'b0;
          r_fail_code <= FC_NONE;
          r_match_cnt <= '0;
          r_tmo_cnt   <= '0;
          r_fail_addr <= '0;
          r_fail_data <= '0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign fail_code = r_fail_code;
  assign match_cnt = r_match_cnt;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

  localparam int N    = 3;
  localparam int TMO  = 10;
  localparam int MAXJ = 128;

  logic        clk = 1'b0;
  logic        reset, start, exp_we, memwrite;
  logic [1:0]  exp_idx;
  logic [31:0] exp_addr, exp_data, dataadr, writedata;
  logic        busy, done, pass, fail;
  logic [1:0]  fail_code;
  logic [1:0]  match_cnt;
  logic [31:0] fail_addr, fail_data;

  mem_write_checker #(.AW(32), .DW(32), .N_EXP(N), .TIMEOUT(TMO),
                      .IGN_ADDR(32'd80), .IGN_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .exp_we(exp_we),
    .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .fail_code(fail_code), .match_cnt(match_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          p;
    logic [1:0]  code;
    int          mc;
    logic [31:0] fa;
    logic [31:0] fd;
    int          at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference table contents, as software believes them to be.
  logic [31:0] m_addr [N];
  logic [31:0] m_data [N];

  // Per-cycle stimulus for one run (index j = j-th RUN cycle; kind 0 = no store).
  int          a_kind [MAXJ];
  logic [31:0] a_addr [MAXJ];
  logic [31:0] a_data [MAXJ];
  bit          force_we = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per verdict, then checks that outputs hold.
  exp_t mon_e;
  exp_t held;
  bit   have_held = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1 && prev_done !== 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_verdict actual=done required=no_verdict");
      end else begin
        mon_e = q.pop_front();
        chk("pass", pass, mon_e.p);
        chk("fail", fail, !mon_e.p);
        chk("busy_at_verdict", busy, 0);
        chk("fail_code", fail_code, mon_e.code);
        chk("match_cnt", match_cnt, mon_e.mc);
        chk("fail_addr", fail_addr, mon_e.fa);
        chk("fail_data", fail_data, mon_e.fd);
        chk("verdict_cycle", cyc, mon_e.at);
        held      = mon_e;
        have_held = 1'b1;
      end
    end else if (done === 1'b1 && have_held) begin
      chk("hold_pass", pass, held.p);
      chk("hold_code", fail_code, held.code);
      chk("hold_match_cnt", match_cnt, held.mc);
      chk("hold_fail_addr", fail_addr, held.fa);
    end
    prev_done = done;
  end

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
    exp_we   = 1'b1;
    exp_idx  = 2'(i);
    exp_addr = a;
    exp_data = d;
    tick();
    exp_we = 1'b0;
    if (i < N) begin
      m_addr[i] = a;
      m_data[i] = d;
    end
  endtask

  task automatic clr_acts();
    for (int j = 0; j < MAXJ; j++) begin
      a_kind[j] = 0;
      a_addr[j] = 32'd0;
      a_data[j] = 32'd0;
    end
  endtask

  task automatic set_act(input int j, input logic [31:0] a, input logic [31:0] d);
    a_kind[j] = 1;
    a_addr[j] = a;
    a_data[j] = d;
  endtask

  // Reference model: walk the run's cycles. Real stores are judged by value
  // against the next unmatched entry. Gaps of TMO cycles without an accepted
  // store end the run.
  task automatic run(input int L);
    int   k, last, vj, c0, kind;
    int   k_after [MAXJ];
    exp_t e;
    k = 0; last = 0; vj = 0;
    e.p = 1'b0; e.code = 2'd0; e.fa = 32'd0; e.fd = 32'd0;
    for (int j = 1; j < MAXJ && vj == 0; j++) begin
      kind = (j <= L) ? a_kind[j] : 0;
      if (kind != 0 && a_addr[j] != 32'd80) begin
        if (a_addr[j] == m_addr[k] && a_data[j] == m_data[k]) begin
          k++;
          last = j;
          if (k == N) begin
            e.p = 1'b1;
            vj  = j;
          end
        end else begin
          e.code = 2'd1;
          e.fa   = a_addr[j];
          e.fd   = a_data[j];
          vj     = j;
        end
      end else if (j - last == TMO) begin
        e.code = 2'd2;
        vj     = j;
      end
      k_after[j] = k;
    end
    e.mc = k;
    c0   = cyc;
    e.at = c0 + 1 + vj;
    q.push_back(e);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= vj; j++) begin
      if (j <= L && a_kind[j] != 0) begin
        memwrite  = 1'b1;
        dataadr   = a_addr[j];
        writedata = a_data[j];
      end else begin
        memwrite  = 1'b0;
        dataadr   = $urandom;
        writedata = $urandom;
      end
      exp_we   = force_we || ($urandom_range(0, 3) == 0);
      exp_idx  = 2'($urandom_range(0, 3));
      exp_addr = $urandom;
      exp_data = $urandom;
      tick();
      if (j < vj) begin
        chk("busy_in_run", busy, 1);
        chk("match_cnt_step", match_cnt, k_after[j]);
      end
    end
    memwrite = 1'b0;
    exp_we   = 1'b0;
    for (int t = 0; t < 5 && q.size() > 0; t++) tick();
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL verdict_missing actual=none required=verdict_by_cycle_%0d", e.at);
      q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic load_std();
    load(0, 32'd84, 32'd1);
    load(1, 32'd88, 32'd2);
    load(2, 32'd92, 32'd3);
  endtask

  task automatic rand_table();
    for (int i = 0; i < N; i++)
      load(i, 32'd80 + 32'd4 * 32'($urandom_range(0, 4)), 32'($urandom_range(0, 3)));
    if ($urandom_range(0, 1) == 1) load(3, $urandom, $urandom);
  endtask

  task automatic rand_acts(output int L);
    int pidle, kg, r;
    L = $urandom_range(1, 40);
    pidle = $urandom_range(10, 70);
    kg = 0;
    clr_acts();
    for (int j = 1; j <= L; j++) begin
      r = $urandom_range(0, 99);
      if (r >= pidle) begin
        r = $urandom_range(0, 99);
        if (r < 15) set_act(j, 32'd80, $urandom);
        else if (r < 92 && kg < N) begin
          set_act(j, m_addr[kg], m_data[kg]);
          kg++;
        end else
          set_act(j, 32'd80 + 32'd4 * 32'($urandom_range(0, 4)), 32'($urandom_range(0, 3)));
      end
    end
  endtask

  initial begin
    int L;
    reset = 1'b1; start = 1'b0; exp_we = 1'b0; exp_idx = 2'd0;
    exp_addr = 32'd0; exp_data = 32'd0; memwrite = 1'b0;
    dataadr = 32'd0; writedata = 32'd0;
    for (int i = 0; i < N; i++) begin
      m_addr[i] = 32'd0;
      m_data[i] = 32'd0;
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_code", fail_code, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_data", fail_data, 0);

    // In-order stores with a tolerated scratch store in between.
    load_std();
    load(3, 32'd84, 32'd9);
    clr_acts();
    set_act(1, 32'd80, 32'd5); set_act(2, 32'd84, 32'd1);
    set_act(4, 32'd88, 32'd2); set_act(5, 32'd92, 32'd3);
    run(5);
    // Wrong address on the first store.
    clr_acts(); set_act(1, 32'd88, 32'd7); run(1);
    // Out-of-order after one match.
    clr_acts(); set_act(1, 32'd84, 32'd1); set_act(2, 32'd92, 32'd3); run(2);
    // Timeout; scratch stores do not extend the window.
    clr_acts(); set_act(3, 32'd80, 32'd1); set_act(7, 32'd80, 32'd2); run(7);
    // Matches landing on the timeout cycle are accepted.
    clr_acts();
    set_act(10, 32'd84, 32'd1); set_act(20, 32'd88, 32'd2); set_act(21, 32'd92, 32'd3);
    run(21);
    // Mismatch on the timeout cycle reports a mismatch.
    clr_acts(); set_act(10, 32'd88, 32'd2); run(10);
    // Table writes during RUN are ignored.
    force_we = 1'b1;
    clr_acts(); set_act(1, 32'd84, 32'd1); set_act(2, 32'd88, 32'd2); set_act(3, 32'd92, 32'd3);
    run(3);
    force_we = 1'b0;
    run(3);

    // Reset in the middle of a run, after one match.
    start = 1'b1; tick(); start = 1'b0;
    memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd1;
    tick();
    memwrite = 1'b0;
    chk("mid_match_cnt", match_cnt, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_match_cnt", match_cnt, 0);
    chk("mid_rst_fail_code", fail_code, 0);
    for (int i = 0; i < N; i++) begin
      m_addr[i] = 32'd0;
      m_data[i] = 32'd0;
    end
    // The table itself was cleared to zeros by reset.
    clr_acts(); set_act(1, 32'd0, 32'd0); set_act(2, 32'd0, 32'd0); set_act(3, 32'd0, 32'd0);
    run(3);
    load_std();
    clr_acts(); set_act(1, 32'd84, 32'd1); set_act(2, 32'd88, 32'd2); set_act(3, 32'd92, 32'd3);
    run(3);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 2) == 0) rand_table();
      rand_acts(L);
      run(L);
    end

    repeat (3) tick();
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_write_checker.md
MEM_WRITE_CHECKER -- requirements
Module: mem_write_checker

Interface
REQ-001 Parameter AW, default 32, data-bus address width.
REQ-002 Parameter DW, default 32, data-bus write-data width.
REQ-003 Parameter N_EXP, default 4, depth of the expected-write table (at least 1).
REQ-004 Parameter TIMEOUT, default 1000, number of RUN cycles allowed between accepted writes (at least 1).
REQ-005 Parameter IGN_ADDR, default 80, scratch address whose writes are tolerated.
REQ-006 Parameter IGN_EN, default 1, enables IGN_ADDR tolerance.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle pulse that begins or restarts checking.
REQ-010 exp_we  in  1  table write strobe.
REQ-011 exp_idx  in  clog2(N_EXP) (at least 1)  table entry index.
REQ-012 exp_addr  in  AW  expected address for the entry.
REQ-013 exp_data  in  DW  expected data for the entry.
REQ-014 memwrite  in  1  monitored store strobe.
REQ-015 dataadr  in  AW  monitored store address.
REQ-016 writedata  in  DW  monitored store data.
REQ-017 busy  out  1  high while in RUN.
REQ-018 done  out  1  high in PASS or FAIL.
REQ-019 pass  out  1  high in PASS.
REQ-020 fail  out  1  high in FAIL.
REQ-021 fail_code  out  2  0 = none, 1 = mismatch, 2 = timeout.
REQ-022 match_cnt  out  clog2(N_EXP+1)  number of accepted writes.
REQ-023 fail_addr / fail_data  out  AW / DW  offending store, captured on mismatch.

Function
REQ-024 The block SHALL implement the states IDLE, RUN, PASS and FAIL; busy, done, pass and fail SHALL be registered decodes of the state.
REQ-025 exp_we SHALL write the table entry at exp_idx in IDLE, PASS or FAIL; exp_we SHALL be ignored in RUN; an exp_idx value of N_EXP or above SHALL be ignored.
REQ-026 start in any non-RUN state SHALL cause the next cycle to be RUN, with match_cnt, the timeout counter, fail_code, fail_addr and fail_data all cleared.
REQ-027 start in RUN SHALL be ignored.
REQ-028 A RUN-cycle store is memwrite=1 sampled at the rising edge; stores outside RUN SHALL be ignored.
REQ-029 A store where dataadr == IGN_ADDR and IGN_EN=1 SHALL be tolerated: no state change and no timeout reset; this check SHALL take priority over matching.
REQ-030 Any other store matching both address and data of entry[match_cnt] SHALL increment match_cnt and clear the timeout counter.
REQ-031 When match_cnt reaches N_EXP, the block SHALL enter PASS on the same edge.
REQ-032 Any other store SHALL enter FAIL with fail_code=1 and capture dataadr/writedata into fail_addr/fail_data.
REQ-033 The timeout counter SHALL increment on each RUN cycle without an accepted store.
REQ-034 When the timeout counter reaches TIMEOUT, the block SHALL enter FAIL with fail_code=2 and leave fail_addr/fail_data at 0.
REQ-035 An accepted or failing store in the cycle the timeout would fire SHALL take priority over the timeout.
REQ-036 In PASS and FAIL, the state and all outputs SHALL hold until start or reset.
REQ-037 Latency: every verdict SHALL be visible one cycle after the deciding edge, i.e. registered outputs.

Reset
REQ-038 reset SHALL take priority over all other inputs in every state, including mid-RUN.
REQ-039 reset SHALL leave the block in IDLE with busy=done=pass=fail=0, fail_code=0, match_cnt=0, timeout counter=0, fail_addr=0, fail_data=0.
REQ-040 reset SHALL clear every table entry to address 0, data 0.

Verification
REQ-041 N_EXP=1, entry0=(84,7); start; store (80,5) then (84,7) -> the (80,5) store is tolerated; pass=1, match_cnt=1, fail_code=0.
REQ-042 Same table; start; store (88,7) -> fail=1, fail_code=1, fail_addr=88, fail_data=7.
REQ-043 TIMEOUT=10; start; no stores -> fail=1 with fail_code=2 exactly 10 cycles after RUN entry; stores to 80 do not extend the window.
REQ-044 N_EXP=3, entries (84,1),(88,2),(92,3); stores issued in order -> match_cnt steps 1,2,3, then pass; stores issued out of order -> fail at the first wrong store.
REQ-045 Assert reset mid-RUN after 1 match -> all outputs 0 on the next cycle; a following start with a reloaded table passes.
REQ-046 Match arriving on the timeout cycle -> accepted, no fail; exp_we during RUN -> table unchanged.
